// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the buffered UART receiver: parity modes and receiver FSM encoding.
package uart_rx_fifo_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side bundle: serial line, pop/clear controls, FIFO head, status and displays.
interface uart_rx_fifo_if #(
  parameter int unsigned N_BITS = 8,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic              rxd;
  logic              pop;
  logic              clear_err;
  logic [N_BITS-1:0] data;
  logic              valid;
  logic [CountW-1:0] count;
  logic              overrun;
  logic              frame_err;
  logic              parity_err;
  logic [6:0]        received_high;
  logic [6:0]        received_low;

  modport master (
    output rxd, pop, clear_err,
    input  data, valid, count, overrun, frame_err, parity_err, received_high, received_low
  );

  modport slave (
    input  rxd, pop, clear_err,
    output data, valid, count, overrun, frame_err, parity_err, received_high, received_low
  );

endinterface

// File: rtl/hexa7seg.sv
// Hex nibble to 7-segment pattern, active-high {g,f,e,d,c,b,a}.
module hexa7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    case (hex_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      4'hF: seg_o = 7'h71;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is read combinationally.
module rx_fifo #(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned AddrW  = $clog2(DEPTH),
  localparam int unsigned CountW = AddrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic              valid_o,
  output logic              full_o,
  output logic [CountW-1:0] count_o
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AddrW-1:0]  wptr_q, rptr_q;
  logic [CountW-1:0] count_q;
  logic              empty, full, do_pop, do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CountW'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  // A pop on the same edge frees the slot, so a push while full is still taken.
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign valid_o = ~empty;
  assign full_o  = full;
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Buffered UART receiver: configurable framing, FWFT byte FIFO, sticky errors, hex display.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned CLOCK_HZ  = 50_000_000,
  parameter int unsigned N_BITS    = 8,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned PARITY    = PARITY_NONE,
  parameter int unsigned DEPTH     = 8
) (
  input logic           clk_i,
  input logic           rst_ni,
  uart_rx_fifo_if.slave rx_if
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW         = $clog2(N_BITS);
  localparam int unsigned CountW       = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] FullBit  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfBit  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BitW-1:0] LastBit  = BitW'(N_BITS - 1);
  localparam logic            LastStop = 1'(STOP_BITS - 1);

  logic [1:0]        sync_q;
  logic              rxd_s;
  rx_state_e         state_q;
  logic [CntW-1:0]   cnt_q;
  logic [BitW-1:0]   bit_q;
  logic              stop_q;
  logic [N_BITS-1:0] shift_q;
  logic              par_ok_q, push_q, perr_q, ferr_q;
  logic              overrun_q, frame_err_q, parity_err_q;
  logic [7:0]        disp_q;
  logic [N_BITS-1:0] fifo_data;
  logic              fifo_valid, fifo_full, ovf;
  logic [CountW-1:0] fifo_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rx_if.rxd};
  end
  assign rxd_s = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      par_ok_q <= 1'b1;
      push_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      push_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      // Timed states count down to zero, then act on the sample.
      if (state_q != StIdle && state_q != StBreak && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        case (state_q)
          StIdle: begin
            if (!rxd_s) begin
              state_q  <= StStart;
              cnt_q    <= HalfBit;
              par_ok_q <= 1'b1;
            end
          end
          StStart: begin
            if (rxd_s) begin
              state_q <= StIdle;
            end else begin
              state_q <= StData;
              cnt_q   <= FullBit;
              bit_q   <= '0;
            end
          end
          StData: begin
            shift_q <= {rxd_s, shift_q[N_BITS-1:1]};
            cnt_q   <= FullBit;
            bit_q   <= bit_q + 1'b1;
            if (bit_q == LastBit) begin
              state_q <= (PARITY != PARITY_NONE) ? StParity : StStop;
              stop_q  <= 1'b0;
            end
          end
          StParity: begin
            cnt_q   <= FullBit;
            state_q <= StStop;
            if ((^shift_q ^ rxd_s) != (PARITY == PARITY_ODD)) begin
              par_ok_q <= 1'b0;
              perr_q   <= 1'b1;
            end
          end
          StStop: begin
            cnt_q <= FullBit;
            if (!rxd_s) begin
              ferr_q  <= 1'b1;
              state_q <= StBreak;
            end else if (stop_q == LastStop) begin
              push_q  <= par_ok_q;
              state_q <= StIdle;
            end else begin
              stop_q <= 1'b1;
            end
          end
          StBreak: begin
            if (rxd_s) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  rx_fifo #(
    .WIDTH (N_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .pop_i   (rx_if.pop),
    .rdata_o (fifo_data),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // When full the head is valid, so a concurrent pop always makes room.
  assign ovf = push_q & fifo_full & ~rx_if.pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      disp_q       <= 8'h00;
    end else begin
      overrun_q    <= ovf    | (overrun_q    & ~rx_if.clear_err);
      frame_err_q  <= ferr_q | (frame_err_q  & ~rx_if.clear_err);
      parity_err_q <= perr_q | (parity_err_q & ~rx_if.clear_err);
      if (fifo_valid) disp_q <= 8'(fifo_data);
    end
  end

  hexa7seg u_seg_high (
    .hex_i (disp_q[7:4]),
    .seg_o (rx_if.received_high)
  );

  hexa7seg u_seg_low (
    .hex_i (disp_q[3:0]),
    .seg_o (rx_if.received_low)
  );

  assign rx_if.data       = fifo_data;
  assign rx_if.valid      = fifo_valid;
  assign rx_if.count      = fifo_count;
  assign rx_if.overrun    = overrun_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: an 8N1 and an 8E1 receiver, both 4 deep, 10 clocks per bit, share one line.
module tb_uart_rx_fifo;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_A = 7'h77;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  int   checks = 0;
  int   passed = 0;

  uart_rx_fifo_if #(.N_BITS(8), .DEPTH(4)) if_n ();
  uart_rx_fifo_if #(.N_BITS(8), .DEPTH(4)) if_p ();

  assign if_n.rxd = rxd;
  assign if_p.rxd = rxd;

  uart_rx_fifo #(
    .BAUD_RATE (100_000),
    .CLOCK_HZ  (1_000_000),
    .N_BITS    (8),
    .STOP_BITS (1),
    .PARITY    (0),
    .DEPTH     (4)
  ) u_dut_n (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rx_if  (if_n)
  );

  uart_rx_fifo #(
    .BAUD_RATE (100_000),
    .CLOCK_HZ  (1_000_000),
    .N_BITS    (8),
    .STOP_BITS (1),
    .PARITY    (2),
    .DEPTH     (4)
  ) u_dut_p (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rx_if  (if_p)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    rxd = 1'b1;
    if_n.pop = 1'b0;
    if_n.clear_err = 1'b0;
    if_p.pop = 1'b0;
    if_p.clear_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit with_par, input logic par,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (with_par) send_bit(par);
    send_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic pop_n();
    if_n.pop = 1'b1;
    @(negedge clk);
    if_n.pop = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (if_n.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_n.valid);
    else passed++;
    checks++;
    if (if_n.count !== 3'd0) $display("FAIL reset_count: got %0d want 0", if_n.count);
    else passed++;
    checks++;
    if ({if_n.overrun, if_n.frame_err, if_n.parity_err} !== 3'b000)
      $display("FAIL reset_flags_n: got %b want 000",
               {if_n.overrun, if_n.frame_err, if_n.parity_err});
    else passed++;
    checks++;
    if ({if_p.overrun, if_p.frame_err, if_p.parity_err} !== 3'b000)
      $display("FAIL reset_flags_p: got %b want 000",
               {if_p.overrun, if_p.frame_err, if_p.parity_err});
    else passed++;
    checks++;
    if (if_n.received_high !== SEG_0 || if_n.received_low !== SEG_0)
      $display("FAIL reset_display: got %h/%h want %h/%h",
               if_n.received_high, if_n.received_low, SEG_0, SEG_0);
    else passed++;
  endtask

  task automatic test_8n1();
    do_reset();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (if_n.valid !== 1'b1) $display("FAIL 8n1_valid: got %b want 1", if_n.valid);
    else passed++;
    checks++;
    if (if_n.data !== 8'hA5) $display("FAIL 8n1_data: got %h want a5", if_n.data);
    else passed++;
    checks++;
    if (if_n.count !== 3'd1) $display("FAIL 8n1_count: got %0d want 1", if_n.count);
    else passed++;
    checks++;
    if (if_n.received_high !== SEG_A || if_n.received_low !== SEG_5)
      $display("FAIL 8n1_display: got %h/%h want %h/%h",
               if_n.received_high, if_n.received_low, SEG_A, SEG_5);
    else passed++;
    checks++;
    if ({if_n.overrun, if_n.frame_err, if_n.parity_err} !== 3'b000)
      $display("FAIL 8n1_flags: got %b want 000",
               {if_n.overrun, if_n.frame_err, if_n.parity_err});
    else passed++;
    pop_n();
    checks++;
    if (if_n.valid !== 1'b0 || if_n.count !== 3'd0)
      $display("FAIL 8n1_pop: got valid %b count %0d want 0/0", if_n.valid, if_n.count);
    else passed++;
  endtask

  task automatic test_parity();
    do_reset();
    // 0x03 has two ones; a parity bit of 1 is wrong in even mode.
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (if_p.parity_err !== 1'b1) $display("FAIL par_err_set: got %b want 1", if_p.parity_err);
    else passed++;
    checks++;
    if (if_p.count !== 3'd0 || if_p.valid !== 1'b0)
      $display("FAIL par_discard: got count %0d valid %b want 0/0", if_p.count, if_p.valid);
    else passed++;
    checks++;
    if (if_p.frame_err !== 1'b0) $display("FAIL par_no_frame: got %b want 0", if_p.frame_err);
    else passed++;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (if_p.valid !== 1'b1 || if_p.data !== 8'h07)
      $display("FAIL par_good: got valid %b data %h want 1/07", if_p.valid, if_p.data);
    else passed++;
    if_p.clear_err = 1'b1;
    @(negedge clk);
    if_p.clear_err = 1'b0;
    @(negedge clk);
    checks++;
    if (if_p.parity_err !== 1'b0) $display("FAIL par_clear: got %b want 0", if_p.parity_err);
    else passed++;
  endtask

  task automatic test_framing();
    do_reset();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(i == 2 || i == 3 || i == 4 || i == 5);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (if_n.frame_err !== 1'b1) $display("FAIL frame_err_set: got %b want 1", if_n.frame_err);
    else passed++;
    checks++;
    if (if_n.valid !== 1'b0) $display("FAIL frame_discard: got valid %b want 0", if_n.valid);
    else passed++;
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (if_n.valid !== 1'b1 || if_n.data !== 8'h11 || if_n.count !== 3'd1)
      $display("FAIL frame_recover: got valid %b data %h count %0d want 1/11/1",
               if_n.valid, if_n.data, if_n.count);
    else passed++;
    checks++;
    if (if_n.frame_err !== 1'b1) $display("FAIL frame_sticky: got %b want 1", if_n.frame_err);
    else passed++;
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (if_n.count !== 3'd4) $display("FAIL ovr_count: got %0d want 4", if_n.count);
    else passed++;
    checks++;
    if (if_n.overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", if_n.overrun);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (if_n.data !== 8'(i)) $display("FAIL ovr_pop%0d: got %h want %h", i, if_n.data, 8'(i));
      else passed++;
      pop_n();
    end
    checks++;
    if (if_n.valid !== 1'b0 || if_n.count !== 3'd0)
      $display("FAIL ovr_empty: got valid %b count %0d want 0/0", if_n.valid, if_n.count);
    else passed++;
    pop_n();
    checks++;
    if (if_n.count !== 3'd0) $display("FAIL ovr_pop_empty: got %0d want 0", if_n.count);
    else passed++;
    checks++;
    if (if_n.received_high !== SEG_0 || if_n.received_low !== SEG_4)
      $display("FAIL ovr_display: got %h/%h want %h/%h",
               if_n.received_high, if_n.received_low, SEG_0, SEG_4);
    else passed++;
  endtask

  task automatic test_glitch();
    do_reset();
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (if_n.valid !== 1'b0 || if_p.valid !== 1'b0)
      $display("FAIL glitch_valid: got %b/%b want 0/0", if_n.valid, if_p.valid);
    else passed++;
    checks++;
    if ({if_n.overrun, if_n.frame_err, if_n.parity_err,
         if_p.overrun, if_p.frame_err, if_p.parity_err} !== 6'b0)
      $display("FAIL glitch_flags: got %b want 000000",
               {if_n.overrun, if_n.frame_err, if_n.parity_err,
                if_p.overrun, if_p.frame_err, if_p.parity_err});
    else passed++;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (if_n.data !== 8'h5A || if_n.count !== 3'd1)
      $display("FAIL glitch_next: got data %h count %0d want 5a/1", if_n.data, if_n.count);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (if_n.valid !== 1'b0 || if_n.count !== 3'd0)
      $display("FAIL mid_reset_fifo: got valid %b count %0d want 0/0", if_n.valid, if_n.count);
    else passed++;
    checks++;
    if (if_n.received_high !== SEG_0 || if_n.received_low !== SEG_0)
      $display("FAIL mid_reset_display: got %h/%h want %h/%h",
               if_n.received_high, if_n.received_low, SEG_0, SEG_0);
    else passed++;
    checks++;
    if ({if_n.overrun, if_n.frame_err, if_n.parity_err} !== 3'b000)
      $display("FAIL mid_reset_flags: got %b want 000",
               {if_n.overrun, if_n.frame_err, if_n.parity_err});
    else passed++;
    send_frame(8'h42, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (if_n.data !== 8'h42 || if_n.count !== 3'd1)
      $display("FAIL mid_reset_next: got data %h count %0d want 42/1", if_n.data, if_n.count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_framing();
    test_overrun();
    test_glitch();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
